// File: rtl/data_memory_param.sv
// Parameterised word-addressed data memory with byte enables,
// programmable wait states and a ready/busy/addrError handshake.
module data_memory_param #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cu_readEnable,
   input  logic                    cu_writeEnable,
   input  logic [ADDR_WIDTH-1:0]   memoryAddy,
   input  logic [DATA_WIDTH-1:0]   writeData,
   input  logic [DATA_WIDTH/8-1:0] byteEnable,
   output logic [DATA_WIDTH-1:0]   dataRAMOutput,
   output logic                    ready,
   output logic                    busy,
   output logic                    addrError
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT =
      4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]         be_q, be_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  enter_done;
   logic                  op_rd;
   logic                  op_wr;
   logic                  in_range;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [DATA_WIDTH-1:0] op_wdata;
   logic [NB-1:0]         op_be;
   logic [IDX_W-1:0]      op_idx;
   logic [DATA_WIDTH-1:0] merged;

   // With zero wait states the access completes on the accepting edge,
   // so the operands come straight from the ports in IDLE.
   always_comb begin
      accept     = (state_q == IDLE) && (cu_readEnable || cu_writeEnable);
      enter_done = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd0));
      if (state_q == IDLE) begin
         op_rd    = cu_readEnable;
         op_wr    = cu_writeEnable;
         op_addr  = memoryAddy;
         op_wdata = writeData;
         op_be    = byteEnable;
      end else begin
         op_rd    = rd_q;
         op_wr    = wr_q;
         op_addr  = addr_q;
         op_wdata = wdata_q;
         op_be    = be_q;
      end
      op_idx   = op_addr[IDX_W-1:0];
      in_range = ({1'b0, op_addr} < LIMIT);
      merged   = mem[op_idx];
      for (int b = 0; b < NB; b++) begin
         if (op_be[b]) begin
            merged[8*b +: 8] = op_wdata[8*b +: 8];
         end
      end
      mem_we = enter_done && op_wr && in_range && !reset;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = memoryAddy;
               wdata_d = writeData;
               be_d    = byteEnable;
               rd_d    = cu_readEnable;
               wr_d    = cu_writeEnable;
               if (WAIT_CYCLES == 0) begin
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      if (enter_done) begin
         if (!in_range) begin
            rdata_d = '0;
         end else if (op_rd) begin
            rdata_d = op_wr ? merged : mem[op_idx];
         end
      end
      ready_d = enter_done;
      err_d   = enter_done && !in_range;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[op_idx] <= merged;
      end
   end

   assign dataRAMOutput = rdata_q;
   assign ready         = ready_q;
   assign busy          = busy_q;
   assign addrError     = err_q;

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface

Parameters:
- REQ-001: The block SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8 and at least 8.
- REQ-002: The block SHALL have parameter ADDR_WIDTH, default 10: word-address width.
- REQ-003: The block SHALL have parameter DEPTH, default 1024: number of implemented words, at most 2^ADDR_WIDTH.
- REQ-004: The block SHALL have parameter WAIT_CYCLES, default 1: wait states inserted between request acceptance and completion, 0 to 15.

Ports:
- REQ-005: The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-006: The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-007: The block SHALL have port cu_readEnable, input, 1 bit: read request from control unit.
- REQ-008: The block SHALL have port cu_writeEnable, input, 1 bit: write request from control unit.
- REQ-009: The block SHALL have port memoryAddy, input, ADDR_WIDTH bits: word address.
- REQ-010: The block SHALL have port writeData, input, DATA_WIDTH bits: write data.
- REQ-011: The block SHALL have port byteEnable, input, DATA_WIDTH/8 bits: per-byte write mask; bit i covers writeData[8i+7:8i].
- REQ-012: The block SHALL have port dataRAMOutput, output, DATA_WIDTH bits: registered read data.
- REQ-013: The block SHALL have port ready, output, 1 bit: one-cycle completion pulse.
- REQ-014: The block SHALL have port busy, output, 1 bit: high while a request is in flight.
- REQ-015: The block SHALL have port addrError, output, 1 bit: one-cycle pulse, coincident with ready, for an out-of-range request.

Function

- REQ-016: The FSM SHALL have states IDLE, WAIT, DONE; busy SHALL be high in WAIT and DONE and low in IDLE.
- REQ-017: In IDLE, a rising edge with cu_readEnable or cu_writeEnable high SHALL accept the request and latch address, data, byteEnable and request type.
- REQ-018: On acceptance, the FSM SHALL go to WAIT with wait counter = WAIT_CYCLES-1, or straight to DONE if WAIT_CYCLES = 0.
- REQ-019: WAIT SHALL decrement the counter each cycle and go to DONE after the cycle in which the counter is 0.
- REQ-020: DONE SHALL last exactly one cycle with ready = 1, then return to IDLE.
- REQ-021: Latency: a request accepted at edge N SHALL produce ready high during cycle N+1+WAIT_CYCLES; a new request is accepted no earlier than the edge ending DONE+1 (IDLE).
- REQ-022: cu_readEnable and cu_writeEnable SHALL be ignored while busy = 1; requests are neither queued nor errored.
- REQ-023: A write SHALL update only the bytes whose byteEnable bit is 1, committed on the edge entering DONE; with byteEnable = 0 it is a no-op that still completes.
- REQ-024: A read SHALL load dataRAMOutput on the edge entering DONE; dataRAMOutput SHALL hold that value until the next read or error completes.
- REQ-025: Simultaneous read and write SHALL be one access: write first, then dataRAMOutput returns the post-write word (write-through).
- REQ-026: An address >= DEPTH SHALL complete with normal latency, with addrError = 1 during DONE, no memory change, and dataRAMOutput = 0.
- REQ-027: Memory contents SHALL be uninitialised at power-up and SHALL NOT be cleared by reset.

Reset

- REQ-028: A reset SHALL force state IDLE, wait counter 0, dataRAMOutput 0, ready 0, busy 0, addrError 0 on the next rising edge.
- REQ-029: A reset during WAIT or DONE SHALL abort the in-flight request, and a write not yet committed SHALL NOT modify memory.
- REQ-030: Reset SHALL take priority over a request presented in the same cycle.

Verification (defaults, WAIT_CYCLES = 1)

- REQ-031: The bench SHALL check: write addr 5, 0xDEADBEEF, byteEnable 4'hF, then read addr 5 -> ready 2 cycles after each acceptance, dataRAMOutput 0xDEADBEEF.
- REQ-032: The bench SHALL check: after the previous, write addr 5, 0x00001122, byteEnable 4'b0011, then read -> dataRAMOutput 0xDEAD1122.
- REQ-033: The bench SHALL check: read addr 1023 with DEPTH = 1000 -> addrError = 1 with ready, dataRAMOutput 0x00000000, memory unchanged.
- REQ-034: The bench SHALL check: read and write together at addr 7 with 0x12345678 -> single ready, dataRAMOutput 0x12345678.
- REQ-035: The bench SHALL check: a new request asserted while busy -> ignored, exactly one ready pulse; repeat with WAIT_CYCLES = 0 (latency 1) and WAIT_CYCLES = 3 (latency 4).
- REQ-036: The bench SHALL check: write addr 9, 0xAAAAAAAA, with reset asserted during WAIT -> no ready, outputs 0, subsequent read of addr 9 returns its prior contents.
